// File: rtl/conv3x3_stream_engine_if.sv
// conv3x3_stream_engine_if
//   Pixel-in and result-out streams of conv3x3_stream_engine.
//   Ports (signal, driven by):
//     valid_in  / pixel_in  : source  -> engine
//     ready_in              : engine  -> source
//     valid_out / dout      : engine  -> sink
//     ready_out             : sink    -> engine
//   Modports: master = the pixel source and result sink; slave = the engine.
//
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both 1. A producer that has raised valid holds valid and data stable until
// that edge. ready may depend combinationally on the other side's signals,
// but valid never depends on ready.
interface conv3x3_stream_engine_if #(
  parameter int DATA_W = 8
);
  logic              valid_in;
  logic              ready_in;
  logic [DATA_W-1:0] pixel_in;
  logic              valid_out;
  logic              ready_out;
  logic [DATA_W-1:0] dout;

  modport master (
    output valid_in, pixel_in, ready_out,
    input  ready_in, valid_out, dout
  );

  modport slave (
    input  valid_in, pixel_in, ready_out,
    output ready_in, valid_out, dout
  );
endinterface

// File: rtl/conv3x3_stream_engine.sv
// conv3x3_stream_engine
//   Streaming 3x3 convolution with loadable weights/bias, padding modes
//   none/zero/edge, optional stride 2, ReLU, arithmetic shift and requantise.
//   Optional build macro: CONV_STREAM_SAT_EN (clamp result to 0..2^(DATA_W-1)-1);
//   without it the low DATA_W bits of the shifted value are kept.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   cfg_we/addr/data    weight (addr 0-8, raster order) and bias (addr 9) writes, idle only
//   img_width/height    frame size, latched on accepted start
//   padding_mode        00 none, 01 zero, 10 edge, 11 illegal
//   stride2, shift_amt  output decimation and post-ReLU shift, latched on start
//   start               begin a frame (accepted only in IDLE)
//   s                   pixel-in / result-out streams (slave modport)
//   busy, frame_done    FSM not idle; pulse after the last result is taken
//   cfg_err             pulse when start is rejected
//   dbg_state           current FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3)
module conv3x3_stream_engine #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int MAX_W  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_addr,
  input  logic [DATA_W-1:0]   cfg_data,
  input  logic [7:0]          img_width,
  input  logic [7:0]          img_height,
  input  logic [1:0]          padding_mode,
  input  logic                stride2,
  input  logic [3:0]          shift_amt,
  input  logic                start,
  conv3x3_stream_engine_if.slave s,
  output logic                busy,
  output logic                frame_done,
  output logic                cfg_err,
  output logic [1:0]          dbg_state
);
  localparam int LB_AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int PW    = 2 * DATA_W;
  localparam logic [8:0]       MAX_W9  = 9'(MAX_W);
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
  state_t state_q, state_d;

  logic [7:0]                w_q, h_q, x_q, x_last;
  logic [8:0]                y_q;
  logic [1:0]                mode_q;
  logic                      stride_q;
  logic [3:0]                shift_q;
  logic signed [DATA_W-1:0]  wgt [9];
  logic signed [ACC_W-1:0]   bias_q;
  logic [DATA_W-1:0]         lb0 [MAX_W];  // row y-1
  logic [DATA_W-1:0]         lb1 [MAX_W];  // row y-2
  logic signed [DATA_W-1:0]  win  [3][3];  // [column][row], column 0 = left, row 0 = top
  logic signed [DATA_W-1:0]  nwin [3][3];
  logic signed [DATA_W-1:0]  col_v [3];
  logic                      s1_valid, valid_out_q, cfg_err_q;
  logic signed [PW-1:0]      prod [9];
  logic [DATA_W-1:0]         dout_q, q;
  logic signed [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]          relu, shifted;
  logic                      legal, pad, zero_pad, stall, is_insert, gen_done;
  logic                      ready_in, accept, step, emit, last_pixel, r_even, c_even, in_range;
  logic [LB_AW-1:0]          lb_idx;
  logic [DATA_W-1:0]         mid, top, bot;

  assign legal = ({1'b0, img_width} >= 9'd3) && ({1'b0, img_width} <= MAX_W9) &&
                 (img_height >= 8'd3) && (padding_mode != 2'b11);
  assign pad        = (mode_q == 2'b01) || (mode_q == 2'b10);
  assign zero_pad   = (mode_q == 2'b01);
  assign stall      = valid_out_q && !s.ready_out;
  // Padded frames get one generated column (x == W) after every row.
  assign is_insert  = pad && (x_q == w_q);
  // Padded frames also generate a bottom row y == H before finishing.
  assign gen_done   = pad ? (y_q == ({1'b0, h_q} + 9'd1)) : (y_q == {1'b0, h_q});
  assign x_last     = pad ? w_q : (w_q - 8'd1);
  assign last_pixel = (x_q == (w_q - 8'd1)) && (y_q == ({1'b0, h_q} - 9'd1));
  assign ready_in   = (state_q == RUN) && !is_insert && !stall;
  assign accept     = ready_in && s.valid_in;
  assign step       = !stall && (((state_q == RUN) && (is_insert || s.valid_in)) ||
                                 ((state_q == DRAIN) && !gen_done));
  assign lb_idx     = x_q[LB_AW-1:0];

  // New window column for sample (y, x): rows y-2, y-1, y with top/bottom padding.
  always_comb begin
    mid = lb0[lb_idx];
    top = lb1[lb_idx];
    bot = s.pixel_in;
    if (pad && (y_q == 9'd1))
      top = zero_pad ? '0 : mid;
    if (pad && (y_q == {1'b0, h_q}))
      bot = zero_pad ? '0 : mid;
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      nwin[0][r] = win[1][r];
      nwin[1][r] = win[2][r];
      nwin[2][r] = '0;
      col_v[r]   = '0;
    end
    col_v[0] = top;
    col_v[1] = mid;
    col_v[2] = bot;
    // Right padding column: zero, or a copy of the last real column.
    if (is_insert)
      for (int r = 0; r < 3; r++) col_v[r] = zero_pad ? '0 : win[2][r];
    for (int r = 0; r < 3; r++) nwin[2][r] = col_v[r];
    // Left padding column is planted when a row starts, replacing stale data.
    if (pad && (x_q == 8'd0))
      for (int r = 0; r < 3; r++) nwin[1][r] = zero_pad ? '0 : col_v[r];
  end

  // Sample (y, x) completes the window centred on output (y-1, x-1) when padded,
  // or on output (y-2, x-2) unpadded; subtracting 2 keeps parity.
  assign r_even   = pad ? y_q[0] : ~y_q[0];
  assign c_even   = pad ? x_q[0] : ~x_q[0];
  assign in_range = pad ? ((y_q >= 9'd1) && (x_q >= 8'd1)) : ((y_q >= 9'd2) && (x_q >= 8'd2));
  assign emit     = step && in_range && (!stride_q || (r_even && c_even));

  always_comb begin
    acc = bias_q;
    for (int k = 0; k < 9; k++) acc = acc + ACC_W'(prod[k]);
    relu    = acc[ACC_W-1] ? '0 : acc;
    shifted = relu >> shift_q;
`ifdef CONV_STREAM_SAT_EN
    q = (shifted > SAT_MAX) ? SAT_MAX[DATA_W-1:0] : shifted[DATA_W-1:0];
`else
    q = shifted[DATA_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && legal) state_d = RUN;
      RUN:     if (accept && last_pixel) state_d = DRAIN;
      DRAIN:   if (gen_done && !s1_valid && !valid_out_q) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 9; k++) wgt[k] <= '0;
      bias_q <= '0;
    end else if (cfg_we && (state_q == IDLE)) begin
      if (cfg_addr < 4'd9) wgt[cfg_addr] <= cfg_data;
      else if (cfg_addr == 4'd9) bias_q <= ACC_W'($signed(cfg_data));
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[lb_idx] <= lb0[lb_idx];
      lb0[lb_idx] <= s.pixel_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {w_q, h_q, mode_q, stride_q, shift_q} <= '0;
      x_q <= '0;
      y_q <= '0;
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 3; r++) win[c][r] <= '0;
      for (int k = 0; k < 9; k++) prod[k] <= '0;
      s1_valid    <= 1'b0;
      valid_out_q <= 1'b0;
      dout_q      <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= (state_q == IDLE) && start && !legal;
      if ((state_q == IDLE) && start && legal) begin
        w_q <= img_width;  h_q <= img_height;  mode_q <= padding_mode;
        stride_q <= stride2;  shift_q <= shift_amt;
        x_q <= '0;  y_q <= '0;
      end
      if (step) begin
        win <= nwin;
        if (x_q == x_last) begin
          x_q <= '0;
          y_q <= y_q + 9'd1;
        end else begin
          x_q <= x_q + 8'd1;
        end
      end
      if (!stall) begin
        s1_valid <= emit;
        for (int k = 0; k < 9; k++) prod[k] <= PW'(wgt[k]) * PW'(nwin[k % 3][k / 3]);
        valid_out_q <= s1_valid;
        dout_q      <= q;
      end
    end
  end

  assign s.ready_in  = ready_in;
  assign s.valid_out = valid_out_q;
  assign s.dout      = dout_q;
  assign busy        = (state_q != IDLE);
  assign frame_done  = (state_q == DONE);
  assign cfg_err     = cfg_err_q;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// tb_conv3x3_stream_engine
//   Table of known-answer frames plus model-checked random frames, and hand
//   sequences for backpressure, mid-frame reset, config errors and writes
//   while busy. Results go through an expected-value queue.
module tb_conv3x3_stream_engine;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 20;
  localparam int MAX_W  = 64;
`ifdef CONV_STREAM_SAT_EN
  localparam int SAT100 = 127;
`else
  localparam int SAT100 = 132;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic [7:0]  img_width, img_height;
  logic [1:0]  padding_mode;
  logic        stride2;
  logic [3:0]  shift_amt;
  logic        start;
  logic        busy, frame_done, cfg_err;
  logic [1:0]  dbg_state;

  conv3x3_stream_engine_if #(.DATA_W(DATA_W)) bus();

  conv3x3_stream_engine #(.DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_W(MAX_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .img_width(img_width), .img_height(img_height), .padding_mode(padding_mode),
    .stride2(stride2), .shift_amt(shift_amt), .start(start), .s(bus.slave),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];
  int out_cnt  = 0;
  int done_cnt = 0;
  logic [7:0] img [256];
  int wts [9];
  int bias_v;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired, got no event, expected one", name);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.valid_out && bus.ready_out) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL extra_output: got %0d, expected no output", bus.dout);
      end else begin
        check("dout", int'(bus.dout), int'(exp_q.pop_front()));
      end
    end
    if (frame_done) done_cnt++;
  end

  // ---------------- model ----------------
  function automatic int pix_at(input int r, input int c, input int w, input int h, input int mode);
    int rr, cc;
    rr = r;
    cc = c;
    if (r < 0 || r >= h || c < 0 || c >= w) begin
      if (mode == 1) return 0;
      rr = (r < 0) ? 0 : ((r >= h) ? h - 1 : r);
      cc = (c < 0) ? 0 : ((c >= w) ? w - 1 : c);
    end
    return int'($signed(img[rr * w + cc]));
  endfunction

  task automatic model_frame(input int w, input int h, input int mode, input int stride, input int shift);
    int oh, ow, off, acc;
    oh  = (mode != 0) ? h : h - 2;
    ow  = (mode != 0) ? w : w - 2;
    off = (mode != 0) ? 0 : 1;
    for (int r = 0; r < oh; r++)
      for (int c = 0; c < ow; c++) begin
        if (stride != 0 && ((r % 2) != 0 || (c % 2) != 0)) continue;
        acc = bias_v;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            acc += wts[dr * 3 + dc] * pix_at(r + off + dr - 1, c + off + dc - 1, w, h, mode);
        if (acc < 0) acc = 0;
        acc = acc >>> shift;
`ifdef CONV_STREAM_SAT_EN
        if (acc > 127) acc = 127;
`endif
        exp_q.push_back(8'(acc));
      end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_cfg();
    for (int k = 0; k < 10; k++) begin
      cfg_we   = 1'b1;
      cfg_addr = 4'(k);
      cfg_data = (k < 9) ? 8'(wts[k]) : 8'(bias_v);
      @(posedge clk); #1;
    end
    cfg_we = 1'b0;
  endtask

  task automatic start_frame(input int w, input int h, input int mode, input int stride, input int shift);
    img_width    = 8'(w);
    img_height   = 8'(h);
    padding_mode = 2'(mode);
    stride2      = stride[0];
    shift_amt    = 4'(shift);
    start        = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
  endtask

  task automatic send_pixels(input int n);
    int guard;
    for (int i = 0; i < n; i++) begin
      bus.pixel_in = img[i];
      bus.valid_in = 1'b1;
      guard = 0;
      @(negedge clk);
      while (!bus.ready_in && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 2000) begin
        fail_now("ready_in_wait");
        break;
      end
      @(posedge clk); #1;
    end
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int guard;
    guard = 0;
    while (done_cnt == d0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("frame_done_count", done_cnt - d0, 1);
    check("exp_queue_empty", exp_q.size(), 0);
    @(negedge clk);
    check("busy_after_done", int'(busy), 0);
    exp_q.delete();
  endtask

  task automatic fill_img(input int n, input int pat, input int pval);
    for (int i = 0; i < n; i++)
      img[i] = (pat == 0) ? 8'(i + 1) : ((pat == 1) ? 8'(pval) : 8'($urandom_range(0, 255)));
  endtask

  // ---------------- known-answer table ----------------
  typedef struct {
    int w; int h; int mode; int stride; int shift;
    int wt; int bias; int pat; int pval; int off; int n;
  } vec_t;
  vec_t vecs [7];
  int   exp_tab [29];

  initial begin
    int d0, o0, g;

    vecs[0] = '{4, 4, 0, 0, 0,  1,    0, 0,   0,  0, 4};
    vecs[1] = '{3, 3, 1, 0, 0,  1,    0, 1,   1,  4, 9};
    vecs[2] = '{3, 3, 2, 0, 0,  1,    0, 1,   1, 13, 9};
    vecs[3] = '{4, 4, 1, 1, 0,  1,    0, 1,   1, 22, 4};
    vecs[4] = '{3, 3, 0, 0, 0,  1,    0, 1, 100, 26, 1};
    vecs[5] = '{3, 3, 0, 0, 3,  1,    0, 1, 100, 27, 1};
    vecs[6] = '{3, 3, 0, 0, 0, -1, -128, 1, 100, 28, 1};
    exp_tab = '{54, 63, 90, 99,
                4, 6, 4, 6, 9, 6, 4, 6, 4,
                9, 9, 9, 9, 9, 9, 9, 9, 9,
                4, 6, 6, 9,
                SAT100, 112, 0};

    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    img_width = '0; img_height = '0; padding_mode = '0;
    stride2 = 1'b0; shift_amt = '0; start = 1'b0;
    bus.valid_in = 1'b0; bus.pixel_in = '0; bus.ready_out = 1'b1;

    // reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready_in",   int'(bus.ready_in), 0);
    check("reset_valid_out",  int'(bus.valid_out), 0);
    check("reset_dout",       int'(bus.dout), 0);
    check("reset_busy",       int'(busy), 0);
    check("reset_frame_done", int'(frame_done), 0);
    check("reset_cfg_err",    int'(cfg_err), 0);
    check("reset_state",      int'(dbg_state), 0);
    @(posedge clk); #1;

    // table-driven frames
    for (int t = 0; t < 7; t++) begin
      for (int k = 0; k < 9; k++) wts[k] = vecs[t].wt;
      bias_v = vecs[t].bias;
      load_cfg();
      fill_img(vecs[t].w * vecs[t].h, vecs[t].pat, vecs[t].pval);
      for (int i = 0; i < vecs[t].n; i++) exp_q.push_back(8'(exp_tab[vecs[t].off + i]));
      d0 = done_cnt;
      start_frame(vecs[t].w, vecs[t].h, vecs[t].mode, vecs[t].stride, vecs[t].shift);
      if (t == 0) begin
        // weight writes during a frame must not land
        check("busy_after_start", int'(busy), 1);
        for (int k = 0; k < 9; k++) wts[k] = 0;
        bias_v = 5;
        load_cfg();
      end
      send_pixels(vecs[t].w * vecs[t].h);
      wait_done(d0);
    end

    // random frames against the model
    for (int t = 0; t < 3; t++) begin
      int w, h, mode, stride, shift;
      w = 3 + t * 2; h = 3 + t; mode = t; stride = t % 2; shift = t;
      for (int k = 0; k < 9; k++) wts[k] = int'($urandom_range(0, 16)) - 8;
      bias_v = int'($urandom_range(0, 127)) - 64;
      load_cfg();
      fill_img(w * h, 2, 0);
      model_frame(w, h, mode, stride, shift);
      d0 = done_cnt;
      start_frame(w, h, mode, stride, shift);
      send_pixels(w * h);
      wait_done(d0);
    end

    // backpressure: hold ready_out low 5 cycles mid-frame
    for (int k = 0; k < 9; k++) wts[k] = 1;
    bias_v = 0;
    load_cfg();
    fill_img(16, 0, 0);
    model_frame(4, 4, 1, 0, 0);
    d0 = done_cnt;
    o0 = out_cnt;
    start_frame(4, 4, 1, 0, 0);
    fork
      send_pixels(16);
      begin
        g = 0;
        while (out_cnt < o0 + 3 && g < 500) begin @(posedge clk); g++; end
        #1 bus.ready_out = 1'b0;
        g = 0;
        @(negedge clk);
        while (!bus.valid_out && g < 500) begin @(negedge clk); g++; end
        if (g >= 500 || exp_q.size() == 0) fail_now("stall_valid_wait");
        else begin
          for (int i = 0; i < 5; i++) begin
            check("stall_valid_out", int'(bus.valid_out), 1);
            check("stall_dout", int'(bus.dout), int'(exp_q[0]));
            check("stall_ready_in", int'(bus.ready_in), 0);
            @(negedge clk);
          end
        end
        @(posedge clk); #1;
        bus.ready_out = 1'b1;
      end
    join
    wait_done(d0);

    // reset mid-frame
    fill_img(16, 0, 0);
    d0 = done_cnt;
    start_frame(4, 4, 0, 0, 0);
    send_pixels(8);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_busy", int'(busy), 0);
    check("midreset_state", int'(dbg_state), 0);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midreset_no_done", done_cnt - d0, 0);
    @(posedge clk); #1;
    // weights were cleared by reset: every output is 0
    fill_img(9, 1, 100);
    exp_q.push_back(8'd0);
    d0 = done_cnt;
    start_frame(3, 3, 0, 0, 0);
    send_pixels(9);
    wait_done(d0);
    // next frame with reloaded weights is correct
    for (int k = 0; k < 9; k++) wts[k] = 1;
    bias_v = 0;
    load_cfg();
    fill_img(16, 0, 0);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(exp_tab[i]));
    d0 = done_cnt;
    start_frame(4, 4, 0, 0, 0);
    send_pixels(16);
    wait_done(d0);

    // rejected starts
    start_frame(2, 4, 0, 0, 0);
    check("width2_cfg_err", int'(cfg_err), 1);
    check("width2_busy", int'(busy), 0);
    @(posedge clk); #1;
    check("cfg_err_pulse_end", int'(cfg_err), 0);
    start_frame(4, 4, 3, 0, 0);
    check("pad11_cfg_err", int'(cfg_err), 1);
    check("pad11_busy", int'(busy), 0);
    start_frame(MAX_W + 1, 4, 0, 0, 0);
    check("wide_cfg_err", int'(cfg_err), 1);
    check("wide_busy", int'(busy), 0);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/conv3x3_stream_engine.md
# conv3x3_stream_engine

Parametrised streaming 3x3 convolution layer with runtime-loadable weights and bias, three padding modes, optional stride 2, and ReLU, shift and requantise output. It sits between the pixel source and the feature-map or pooling stage. It replaces the fixed-kernel window, conv and ReLU chain with a single block. The block has ready/valid backpressure on both sides and a frame-level control FSM.

## Interface
- DATA_W, 8, pixel, weight and output width (signed two's complement in, unsigned out)
- ACC_W, 20, accumulator width; must be >= 2*DATA_W+4
- MAX_W, 64, maximum image width (line-buffer depth, 2 lines)
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cfg_we  in  1  weight/bias write strobe
- cfg_addr  in  4  0-8 = weight k (raster order, row 0 = top), 9 = bias
- cfg_data  in  DATA_W  write data; bias is sign-extended to ACC_W
- img_width, img_height  in  8 each  frame size, sampled on accepted start
- padding_mode  in  2  00 none, 01 zero, 10 edge-replicate, 11 illegal
- stride2  in  1  1 = emit only even output rows and even output columns
- shift_amt  in  4  arithmetic right shift applied after ReLU
- start  in  1  begin frame (accepted only in IDLE)
- valid_in / ready_in  in / out  1 / 1  input pixel handshake
- pixel_in  in  DATA_W  raster-order pixel
- valid_out / ready_out  out / in  1 / 1  output handshake
- dout  out  DATA_W  requantised result
- busy  out  1  FSM not in IDLE
- frame_done  out  1  one-cycle pulse after the last output is accepted
- cfg_err  out  1  one-cycle pulse when start is rejected

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- **IDLE to RUN:** on start with a legal config.
  - Legal: 3 <= width <= MAX_W, height >= 3, padding_mode != 11.
  - Otherwise pulse cfg_err and stay in IDLE.
- **RUN:** accept W*H pixels. Two line buffers and a 3x3 shift window form the neighbourhood.
  - With padding mode 01 or 10, one internal column-insert cycle follows each row's last pixel. ready_in is 0 during that cycle.
- **RUN to DRAIN:** after the last pixel is accepted.
- **DRAIN:**
  - Mode 00: only flushes the pipeline.
  - Modes 01 and 10: additionally generate the bottom padding row internally, W+1 cycles, ready_in = 0.
- **DRAIN to DONE:** when the pipeline is empty and the last output is accepted.
- **DONE:** pulse frame_done, then go to IDLE.
- **Output size:**
  - Mode 00: (W-2) x (H-2).
  - Modes 01 and 10: W x H.
  - stride2 keeps output coordinates (r,c) with r and c both even: ceil(n/2) per dimension.
- **Padding:** zero mode substitutes 0 outside the image. Edge mode substitutes the nearest in-image pixel (corners use the corner pixel).
- **Arithmetic:**
  - acc = sum(w_k * p_k) + bias, full precision in ACC_W.
  - ReLU: negative becomes 0.
  - Then >>> shift_amt.
  - Then requantise per Configuration.
- **cfg_we:** writes take effect when busy = 0 and are ignored when busy = 1. Weights and bias reset to 0.
- **Config latching:** config inputs are latched on accepted start. Changes during a frame are ignored.

## Timing
- **Reset values:** ready_in, valid_out, busy, frame_done and cfg_err are 0; dout = 0; FSM in IDLE; window and line-buffer valid tracking cleared.
- **ready_in:** 1 only in RUN, when not in a column-insert cycle and not stalled.
- **Pipeline:**
  - Stage 1 registers the 9 products.
  - Stage 2 registers acc, ReLU, shift and requantise into dout.
  - valid_out rises 2 cycles after the cycle whose sample (accepted or internally generated) completes the window.
- **Stall:** valid_out && !ready_out freezes the whole pipeline, including internal insert/drain generation.
  - dout and valid_out hold stable while stalled.
  - No sample or output is dropped or duplicated.
- **Simultaneous events:**
  - cfg_we together with start in IDLE: the write lands and the new frame uses the new value.
  - start while busy: ignored, no cfg_err.
- **Reset mid-frame:** returns to IDLE next edge. Partial frame discarded, no frame_done. Weights also reset.
- **Throughput:** 1 output per cycle at full rate, excluding stride2 skips and insert cycles.

## Configuration
- `CONV_STREAM_SAT_EN` defined: the shifted value clamps to [0, 2^(DATA_W-1)-1]. Default DATA_W = 8 gives 0..127.
- Undefined: dout takes the low DATA_W bits of the shifted value (wrap).

## Test plan
- 4x4 pixels 1..16, mode 00, all weights 1, bias 0, shift 0 -> dout 54, 63, 90, 99, then frame_done.
- 3x3 all ones, mode 01, weights 1 -> 4, 6, 4, 6, 9, 6, 4, 6, 4. Same input with mode 10 -> nine outputs of 9.
- 4x4 all ones, mode 01, stride2 = 1 -> 4, 6, 6, 9.
- 3x3 all 100, mode 00, weights 1, shift 0 -> 127 with `CONV_STREAM_SAT_EN`, 8'h84 without. Same with shift 3 -> 112 in both builds. Bias -128 with weights -1 -> 0 (ReLU).
- Hold ready_out = 0 for 5 cycles mid-frame -> dout stable, ready_in = 0, full output sequence unchanged. Negate rst_n mid-frame -> busy = 0 next cycle, no frame_done, next frame correct.
- start with width 2 or padding 11 -> cfg_err pulse, busy stays 0. cfg_we while busy -> weights unchanged.
